// File: rtl/data_mem_responder_pkg.sv
`ifndef MEM_ADDR_WIDTH
`define MEM_ADDR_WIDTH 10
`endif
`ifndef REG_DATA_WIDTH
`define REG_DATA_WIDTH 32
`endif
`ifndef MEM_TRANSFER_WIDTH
`define MEM_TRANSFER_WIDTH 4
`endif
`ifndef GNT_WAIT_WIDTH
`define GNT_WAIT_WIDTH 3
`endif

// Shared widths and types for the data-memory responder.
// Width defaults fall back to the local values when the shared defines are absent.
package data_mem_responder_pkg;

    localparam int unsigned DEF_MEM_ADDR_WIDTH = `MEM_ADDR_WIDTH;
    localparam int unsigned DEF_DATA_WIDTH     = `REG_DATA_WIDTH;
    localparam int unsigned DEF_TRANSFER_WIDTH = `MEM_TRANSFER_WIDTH;
    localparam int unsigned GNT_WAIT_WIDTH     = `GNT_WAIT_WIDTH;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } mem_op_e;

endpackage

// File: rtl/mem_sram_bank.sv
// Single-port word array with per-byte write enables and a registered read port.
// Contents are not reset; only the read-data register is.
module mem_sram_bank #(
    parameter int unsigned IDX_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BE_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_we,
    input  logic [IDX_WIDTH-1:0]  i_idx,
    input  logic [BE_WIDTH-1:0]   i_be,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    localparam int unsigned DEPTH = 1 << IDX_WIDTH;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-lane writes commit at the accepting edge.
    always_ff @(posedge clk) begin
        if (i_en && i_we) begin
            for (int k = 0; k < int'(BE_WIDTH); k++) begin
                if (i_be[k]) begin
                    r_mem[i_idx][8*k +: 8] <= i_wdata[8*k +: 8];
                end
            end
        end
    end

    // Read data holds its value across writes and idle cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (i_en && !i_we) begin
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_responder.sv
// Request/grant/rvalid memory responder with programmable grant wait states.
// Holds the wait counter, grant logic and response-valid register; storage lives in the bank.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = DEF_MEM_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TRANSFER_WIDTH = DEF_TRANSFER_WIDTH,
    parameter int unsigned GNT_WAIT       = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    input  logic                      we_i,
    input  logic [MEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [TRANSFER_WIDTH-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]     wdata_i,
    output logic [DATA_WIDTH-1:0]     rdata_o
);

    localparam int unsigned               WORD_IDX_WIDTH = MEM_ADDR_WIDTH - 2;
    localparam logic [GNT_WAIT_WIDTH-1:0] GNT_WAIT_CNT   = GNT_WAIT_WIDTH'(GNT_WAIT);

    logic [GNT_WAIT_WIDTH-1:0] r_cnt;
    logic [GNT_WAIT_WIDTH-1:0] w_cnt_nxt;
    logic                      r_rvalid;
    logic                      w_accept;
    logic                      w_is_write;
    logic                      w_unused;
    mem_op_e                   w_op;

    assign w_op       = mem_op_e'(we_i);
    assign w_is_write = (w_op == OP_WRITE);

    // Combinational grant so a zero wait count accepts in the request cycle.
    assign gnt_o    = req_i && (r_cnt == GNT_WAIT_CNT);
    assign w_accept = req_i && gnt_o;

    // A dropped request restarts the wait from zero.
    always_comb begin
        w_cnt_nxt = '0;
        if (w_accept) begin
            w_cnt_nxt = '0;
        end else if (req_i) begin
            w_cnt_nxt = r_cnt + GNT_WAIT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_rvalid <= 1'b0;
        end else begin
            r_cnt    <= w_cnt_nxt;
            r_rvalid <= w_accept;
        end
    end

    assign rvalid_o = r_rvalid;

    mem_sram_bank #(
        .IDX_WIDTH  (WORD_IDX_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BE_WIDTH   (TRANSFER_WIDTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_en    (w_accept),
        .i_we    (w_is_write),
        .i_idx   (addr_i[MEM_ADDR_WIDTH-1:2]),
        .i_be    (be_i),
        .i_wdata (wdata_i),
        .o_rdata (rdata_o)
    );

    // Sub-word address bits carry no meaning for word transfers.
    assign w_unused = ^addr_i[1:0];

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's request/grant/rvalid data-memory port. It accepts one word-wide transaction per grant, applies byte-lane writes, and returns registered read data with a one-cycle `rvalid_o` pulse. The number of grant wait states is programmable, so the core's stall logic can be exercised against slow memory. It sits between the core's data port and the top-level interconnect. It can also serve as the program-memory responder with writes tied off.

## Interface
Parameters:
- `MEM_ADDR_WIDTH`, 10: byte address width. Depth is 2^(MEM_ADDR_WIDTH-2) words.
- `DATA_WIDTH`, 32: word width.
- `TRANSFER_WIDTH`, 4: byte-enable width, equal to DATA_WIDTH/8.
- `GNT_WAIT`, 0: cycles `req_i` must be held before `gnt_o` asserts. Legal range 0..7.

Ports:
- `clk` in 1: clock. One clock domain only.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_i` in 1: transaction request from the core.
- `gnt_o` out 1: grant. The transaction is accepted on the edge where `req_i & gnt_o` is high.
- `rvalid_o` out 1: response valid. Pulses once per granted read or write.
- `we_i` in 1: 1 = write, 0 = read.
- `addr_i` in MEM_ADDR_WIDTH: byte address. Bits [1:0] are ignored.
- `be_i` in TRANSFER_WIDTH: byte-lane write enables, used on writes only.
- `wdata_i` in DATA_WIDTH: write data.
- `rdata_o` out DATA_WIDTH: read data, valid while `rvalid_o` is high.

## Operation
- Wait counter `cnt` is 3 bits.
- `gnt_o = req_i && (cnt == GNT_WAIT)`. This is combinational, so `GNT_WAIT=0` grants in the same cycle as the request.
- Counter update on each edge:
  - if `req_i & gnt_o`: `cnt <= 0`.
  - else if `req_i`: `cnt <= cnt+1`.
  - else: `cnt <= 0`.
- A request withdrawn before grant is discarded with no side effects. This is a protocol violation by the initiator, but it is tolerated.
- Word index is `addr_i[MEM_ADDR_WIDTH-1:2]`. All in-range addresses are valid; there is no error response.
- Granted write: each byte lane k with `be_i[k]=1` is written with `wdata_i[8k+7:8k]` at the grant edge. Other lanes are unchanged. `be_i=0` writes nothing but still responds. `rdata_o` holds its previous value.
- Granted read: `rdata_o <= mem[index]` at the grant edge. `be_i` is ignored.
- `rvalid_o <= req_i & gnt_o`, registered, for both reads and writes.
- Only one transaction is outstanding at a time. A new grant can coincide with the previous `rvalid_o`, which makes back-to-back transfers one per cycle when `GNT_WAIT=0`.
- Read-after-write to the same word on consecutive grants returns the new data, because the write commits at its grant edge before the read samples.
- Reset (asynchronous, any cycle):
  - `rvalid_o=0`, `rdata_o=0`, `cnt=0`.
  - `gnt_o` follows from `cnt=0`.
  - A response in flight is dropped.
  - Memory contents are not cleared.

## Timing
- Request-to-grant: `GNT_WAIT` cycles, assuming `req_i` is held.
- Grant-to-rvalid: 1 cycle, exactly, for reads and writes.
- Request-to-rvalid: `GNT_WAIT+1` cycles.
- Throughput: one transaction per `GNT_WAIT+1` cycles with `req_i` held continuously.
- Initiator obligation: `addr_i`, `we_i`, `be_i` and `wdata_i` stay stable from request assertion until the grant edge. The responder samples them only at the grant edge.
- `rvalid_o` stays high for exactly one cycle per grant. There is no backpressure on responses.

## Structure
- Width macros (`MEM_ADDR_WIDTH`, `REG_DATA_WIDTH`, `MEM_TRANSFER_WIDTH`) come from the shared `defines.vh` under `CUSTOM_DEFINE`, with the parameter defaults above as fallback.
- Add a `GNT_WAIT_WIDTH` (3) constant to `defines.vh`.
- Sub-module `mem_sram_bank`: single-port array of 2^(MEM_ADDR_WIDTH-2) x DATA_WIDTH with per-byte write enable and registered read.
- The top module holds the wait counter, the grant logic and the `rvalid_o` register.

## Test plan
- **Reset:** assert `rst_n=0` mid-read with `GNT_WAIT=2` -> `rvalid_o=0` and `rdata_o=0` immediately. After release, `req_i=1` gives `gnt_o` 2 cycles later.
- **Full-word write then read:** `GNT_WAIT=0`; write addr 0x010, be 4'hF, data 0xDEADBEEF, then read 0x010 on the next cycle -> both granted same-cycle. `rvalid_o` appears on the 2 following cycles, and the read returns 0xDEADBEEF.
- **Byte lanes:** write 0x11223344 with be 4'hF, then 0xAABBCCDD with be 4'b0101 to the same word -> read returns 0x11BB33DD.
- **Wait states:** `GNT_WAIT=3`, `req_i` held with reads -> `gnt_o` on cycle 3, `rvalid_o` on cycle 4, next `gnt_o` on cycle 7.
- **Withdrawn request:** `GNT_WAIT=3`; `req_i` high for 2 cycles then low -> no `gnt_o`, no `rvalid_o`, memory unchanged, and the next request again waits 3 cycles.
- **Address aliasing:** read addr 0x013 after writing 0xCAFEF00D to 0x010 -> returns 0xCAFEF00D (bits [1:0] ignored).
